// File: rtl/alu_pkg.sv
// Shared opcode, flag-bit and FSM-state definitions for the execute unit and
// the instruction decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MULU = 4'd7,
    OP_DIVU = 4'd8,
    OP_REMU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Builds a flags word: upper 12 bits pass through, low nibble is Z/N/C/V.
  function automatic logic [15:0] pack_flags(input logic [11:0] hi,
                                             input logic v, input logic c,
                                             input logic n, input logic z);
    logic [15:0] f;
    f         = {hi, 4'h0};
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/execute_unit_if.sv
// Operation request / result bundle between the issue logic and the execute unit.
interface execute_unit_if #(parameter int DataWidth = 16);
  logic                 Start;
  logic [3:0]           Op;
  logic [DataWidth-1:0] OperandB;
  logic [DataWidth-1:0] OperandC;
  logic [15:0]          FlagsIn;
  logic                 Busy;
  logic                 Done;
  logic [DataWidth-1:0] Result;
  logic [15:0]          NewFlags;
  logic                 UpdateFlags;

  modport master (
    output Start, Op, OperandB, OperandC, FlagsIn,
    input  Busy, Done, Result, NewFlags, UpdateFlags
  );

  modport slave (
    input  Start, Op, OperandB, OperandC, FlagsIn,
    output Busy, Done, Result, NewFlags, UpdateFlags
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle over DataWidth cycles; done marks the cycle presenting the final result.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [DataWidth-1:0] opnd_a,
  input  logic [DataWidth-1:0] opnd_b,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] result,
  output logic                 carry
);

  localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  // hi/lo hold {partial product, multiplier} or {remainder, quotient}.
  logic [DataWidth-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d, is_div_q, is_div_d, want_rem_q, want_rem_d;

  logic [DataWidth:0]   mul_sum, div_shift, div_diff;
  logic [DataWidth-1:0] hi_step, lo_step;
  logic                 last;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[DataWidth-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      hi_step = div_diff[DataWidth] ? div_shift[DataWidth-1:0] : div_diff[DataWidth-1:0];
      lo_step = {lo_q[DataWidth-2:0], ~div_diff[DataWidth]};
    end else begin
      hi_step = mul_sum[DataWidth:1];
      lo_step = {mul_sum[0], lo_q[DataWidth-1:1]};
    end
  end

  assign last   = busy_q && (cnt_q == CntW'(DataWidth - 1));
  assign busy   = busy_q;
  assign done   = last;
  assign result = (is_div_q && want_rem_q) ? hi_step : lo_step;
  assign carry  = !is_div_q && (|hi_step);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    is_div_d   = is_div_q;
    want_rem_d = want_rem_q;
    if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end else if (start) begin
      hi_d       = '0;
      lo_d       = opnd_a;
      opnd_d     = opnd_b;
      cnt_d      = '0;
      busy_d     = 1'b1;
      is_div_d   = (op == OP_DIVU) || (op == OP_REMU);
      want_rem_d = (op == OP_REMU);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      is_div_q   <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      is_div_q   <= is_div_d;
      want_rem_q <= want_rem_d;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute unit: single-cycle ALU ops plus iterative MULU/DIVU/REMU, with
// registered Result/NewFlags and a one-cycle Done pulse for write-back.
module execute_unit
  import alu_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input logic          Clk,
  input logic          Reset,
  execute_unit_if.slave bus
);

  localparam int Msb = DataWidth - 1;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d, upd_q, upd_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic [15:0]          flags_q, flags_d;
  logic [11:0]          flags_hi_q, flags_hi_d;

  logic                 accept, div_zero, go_iter;
  logic                 md_busy, md_done, md_carry;
  logic [DataWidth-1:0] md_result;

  logic [DataWidth-1:0] b, c, alu_res;
  logic [DataWidth:0]   add_w, sub_w, shl_w, shr_w;
  logic [3:0]           amt;
  logic                 alu_c, alu_v, alu_defined;

  assign b        = bus.OperandB;
  assign c        = bus.OperandC;
  assign amt      = c[3:0];
  assign accept   = bus.Start && (state_q != ST_ITER);
  assign div_zero = (c == '0);
  assign go_iter  = accept && ((bus.Op == OP_MULU) ||
                               (((bus.Op == OP_DIVU) || (bus.Op == OP_REMU)) && !div_zero));

  muldiv_iter #(.DataWidth(DataWidth)) u_muldiv (
    .clk    (Clk),
    .rst    (Reset),
    .start  (go_iter),
    .op     (bus.Op),
    .opnd_a (b),
    .opnd_b (c),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .carry  (md_carry)
  );

  always_comb begin
    add_w       = {1'b0, b} + {1'b0, c};
    sub_w       = {1'b0, b} - {1'b0, c};
    shl_w       = {1'b0, b} << amt;
    shr_w       = {b, 1'b0} >> amt;
    alu_res     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_defined = 1'b1;
    case (bus.Op)
      OP_ADD: begin
        alu_res = add_w[Msb:0];
        alu_c   = add_w[DataWidth];
        alu_v   = (b[Msb] == c[Msb]) && (add_w[Msb] != b[Msb]);
      end
      OP_SUB: begin
        alu_res = sub_w[Msb:0];
        alu_c   = sub_w[DataWidth];
        alu_v   = (b[Msb] != c[Msb]) && (sub_w[Msb] != b[Msb]);
      end
      OP_AND: alu_res = b & c;
      OP_OR:  alu_res = b | c;
      OP_XOR: alu_res = b ^ c;
      OP_SHL: begin
        alu_res = shl_w[Msb:0];
        alu_c   = shl_w[DataWidth];
      end
      OP_SHR: begin
        alu_res = shr_w[DataWidth:1];
        alu_c   = shr_w[0];
      end
      // Only reachable here on divide by zero; real divides go iterative.
      OP_DIVU: begin
        alu_res = '1;
        alu_v   = 1'b1;
      end
      OP_REMU: begin
        alu_res = b;
        alu_v   = 1'b1;
      end
      default: alu_defined = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    upd_d      = 1'b0;
    result_d   = result_q;
    flags_d    = flags_q;
    flags_hi_d = flags_hi_q;
    case (state_q)
      ST_ITER: begin
        busy_d = 1'b1;
        if (md_done) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          upd_d    = 1'b1;
          result_d = md_result;
          flags_d  = pack_flags(flags_hi_q, 1'b0, md_carry, md_result[Msb], md_result == '0);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          flags_hi_d = bus.FlagsIn[15:4];
          if (go_iter) begin
            state_d = ST_ITER;
            busy_d  = 1'b1;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            upd_d    = alu_defined;
            result_d = alu_res;
            flags_d  = alu_defined
                     ? pack_flags(bus.FlagsIn[15:4], alu_v, alu_c, alu_res[Msb], alu_res == '0)
                     : bus.FlagsIn;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      upd_q      <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      flags_hi_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      upd_q      <= upd_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      flags_hi_q <= flags_hi_d;
    end
  end

  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.UpdateFlags = upd_q;
  assign bus.Result      = result_q;
  assign bus.NewFlags    = flags_q;

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have parameter DataWidth, default 16, meaning operand/result width and iteration count for multi-cycle ops.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Clk  input  1  rising-edge clock, shared with the register file.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 Start  input  1  request to execute one operation; sampled on Clk rise.
REQ-006 Op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MULU, 8 DIVU, 9 REMU; 10-15 undefined.
REQ-007 OperandB  input  DataWidth  first operand, from register-file read port B.
REQ-008 OperandC  input  DataWidth  second operand, from register-file read port C.
REQ-009 FlagsIn  input  16  current flags register contents.
REQ-010 Busy  output  1  multi-cycle operation in progress.
REQ-011 Done  output  1  one-cycle pulse: Result/NewFlags valid, write-back enabled.
REQ-012 Result  output  DataWidth  value for register-file write data.
REQ-013 NewFlags  output  16  value for register-file flags write.
REQ-014 UpdateFlags  output  1  flags write enable; asserted only together with Done.

Function
REQ-015 States SHALL be IDLE, ITER, DONE; reset state IDLE.
REQ-016 IDLE + Start + single-cycle op (0-6, 10-15) SHALL go to DONE at that edge; operands latched at that edge.
REQ-017 IDLE + Start + MULU/DIVU/REMU SHALL latch operands, clear iteration counter, go to ITER.
REQ-018 ITER SHALL perform one shift-add (MULU) or restoring shift-subtract (DIVU/REMU) step per cycle, DataWidth cycles, then go to DONE.
REQ-019 Latency: Done high in the cycle after the Start edge for single-cycle ops; DataWidth+1 cycles after the Start edge for multi-cycle ops.
REQ-020 DONE SHALL last exactly one cycle; Done=1, Busy=0; next state IDLE, or accept a new Start in the same manner as IDLE.
REQ-021 Busy SHALL be 1 exactly while state is ITER; Start while Busy SHALL be ignored.
REQ-022 Result and NewFlags SHALL hold their last value until the next Done.
REQ-023 ADD/SUB: modulo 2^DataWidth; C = carry out (ADD) or borrow (SUB); V = signed overflow.
REQ-024 AND/OR/XOR: C=0, V=0.
REQ-025 SHL/SHR: logical shift of B by C[3:0]; C = last bit shifted out, 0 when shift amount 0; V=0.
REQ-026 MULU: Result = low DataWidth bits of B*C; C = 1 if high half nonzero; V=0.
REQ-027 DIVU returns quotient, REMU returns remainder of B/C, unsigned; C=0, V=0.
REQ-028 Divide by zero SHALL skip ITER (single-cycle latency): DIVU Result=all ones, REMU Result=B, V=1, C=0.
REQ-029 Flag bits: 0 Z (Result==0), 1 N (Result MSB), 2 C, 3 V; NewFlags[15:4] = FlagsIn[15:4] sampled at the Start edge.
REQ-030 Defined ops SHALL assert UpdateFlags with Done; undefined ops SHALL give Result=0, NewFlags=FlagsIn, UpdateFlags=0, Done still pulsed.

Reset
REQ-031 Reset SHALL force state IDLE, Busy=0, Done=0, UpdateFlags=0, Result=0, NewFlags=0, counter=0 at the next edge.
REQ-032 Reset during ITER or DONE SHALL abort the operation with no Done pulse; Reset wins over simultaneous Start.

Structure
REQ-033 Opcode constants, flag bit positions and state encodings SHALL live in a shared package, alu_pkg, used also by the decoder.
REQ-034 The iterative multiply/divide datapath SHALL be one sub-module, muldiv_iter, with Start/Done handshake; everything else in execute_unit.

Verification
REQ-035 ADD B=0x7FFF C=0x0001 -> Done next cycle, Result=0x8000, N=1, V=1, C=0, Z=0, UpdateFlags=1.
REQ-036 SUB B=0x0000 C=0x0001, FlagsIn=0xA5F0 -> Result=0xFFFF, C=1, N=1, NewFlags[15:4]=0xA5F.
REQ-037 MULU B=0x0100 C=0x0100 -> Busy for 16 cycles, Done at cycle 17, Result=0x0000, Z=1, C=1; Start during Busy ignored.
REQ-038 DIVU B=100 C=7 -> Result=14; REMU same operands -> Result=2; DIVU C=0 -> Done next cycle, Result=0xFFFF, V=1.
REQ-039 Reset asserted on 5th ITER cycle of DIVU -> no Done pulse, all outputs 0, new ADD accepted next cycle.
REQ-040 Op=12 -> Done pulsed, UpdateFlags=0, Result=0; back-to-back Start in DONE cycle accepted.
